// File: rtl/ysyx_23060111_dmem_resp.sv
// Single-port data-memory responder for the EXU load/store path, with a fixed response latency.
// Latency: rsp_valid rises LAT cycles after the accept edge. The accept cycle counts as cycle 1.
// Backpressure: there is one transaction in flight and no queuing. The response is held until rsp_ready.
//
// Ports:
//   clk, rst                    single clock, asynchronous active-high reset
//   req_valid/req_ready         request handshake (req_ready high only in IDLE)
//   req_wen, req_addr,          write enable, byte address, lane-aligned write data,
//   req_wdata, req_mask         byte-lane mask (write enables / returned read lanes)
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata, rsp_err          masked read data (0 for writes), access error flag
//
// Optional feature: define YSYX_23060111_DMEM_MISALIGN_ERR_EN to reject non-word-aligned
// addresses with rsp_err=1. Such accesses perform no write commit and return zero data.
// Without the macro, req_addr[1:0] is ignored and rsp_err is tied low.
module ysyx_23060111_dmem_resp #(
  parameter int AW  = 8,  // word-address width, storage is 2**AW words
  parameter int LAT = 2   // response latency, 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_mask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept;
  logic        to_resp;   // edge on which the access takes effect (write commit / read sample)

  // Storage is deliberately left uninitialised and is never touched by reset.
  logic [31:0] mem [0:(1<<AW)-1];

  // Captured request, used when the access completes in WAIT.
  logic          wen_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    mask_q;

  // Effective access fields on the to_resp edge. For LAT=1 the access completes on the
  // accept edge itself, so the live request is used because the capture registers are not
  // loaded yet.
  logic          c_wen;
  logic [AW-1:0] c_idx;
  logic [31:0]   c_wdata;
  logic [3:0]    c_mask;
  logic          c_mis;

  logic [31:0]   rdata_q;

  function automatic logic [31:0] lane_bits(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state / outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    to_resp   = 1'b0;
    req_ready = (state == IDLE) && !rst;
    accept    = req_valid && req_ready;
    rsp_valid = (state == RESP);

    case (state)
      IDLE: begin
        if (accept) begin
          if (LAT == 1) begin
            state_nxt = RESP;
            to_resp   = 1'b1;
            cnt_nxt   = 4'd0;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(LAT - 1);
          end
        end
      end
      WAIT: begin
        // The counter is loaded with LAT-1 at accept. Leaving at 1 puts the RESP entry on
        // edge LAT-1 after accept, so that the response appears in cycle LAT.
        if (cnt == 4'd1) begin
          state_nxt = RESP;
          to_resp   = 1'b1;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      mask_q  <= 4'd0;
    end else if (accept) begin
      wen_q   <= req_wen;
      idx_q   <= req_addr[AW+1:2];
      wdata_q <= req_wdata;
      mask_q  <= req_mask;
    end
  end

  always_comb begin
    if (state == IDLE) begin
      c_wen   = req_wen;
      c_idx   = req_addr[AW+1:2];
      c_wdata = req_wdata;
      c_mask  = req_mask;
    end else begin
      c_wen   = wen_q;
      c_idx   = idx_q;
      c_wdata = wdata_q;
      c_mask  = mask_q;
    end
  end

`ifdef YSYX_23060111_DMEM_MISALIGN_ERR_EN
  logic mis_q;
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else if (accept) begin
      mis_q <= (req_addr[1:0] != 2'b00);
    end
  end

  assign c_mis = (state == IDLE) ? (req_addr[1:0] != 2'b00) : mis_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (to_resp) begin
      err_q <= c_mis;
    end else if (state == RESP && rsp_ready) begin
      err_q <= 1'b0;
    end
  end

  assign rsp_err = err_q;

  // Address bits above the storage index only alias.
  logic unused_addr;
  assign unused_addr = ^req_addr[31:AW+2];
`else
  assign c_mis   = 1'b0;
  assign rsp_err = 1'b0;

  // Byte offset and address bits above the storage index play no part in the access.
  logic unused_addr;
  assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

  // ---------------------------------------------------------------------------
  // Storage write: only on the completion edge, and never while reset is asserted,
  // so a transaction abandoned by reset leaves memory untouched.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && to_resp && c_wen && !c_mis) begin
      for (int b = 0; b < 4; b++) begin
        if (c_mask[b]) begin
          mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response data: sampled on the completion edge and held through RESP.
  // Earlier writes have already committed, so a later read sees them.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 32'd0;
    end else if (to_resp) begin
      if (c_wen || c_mis) begin
        rdata_q <= 32'd0;
      end else begin
        rdata_q <= mem[c_idx] & lane_bits(c_mask);
      end
    end else if (state == RESP && rsp_ready) begin
      rdata_q <= 32'd0;
    end
  end

  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_ysyx_23060111_dmem_resp.sv
// Directed bench for ysyx_23060111_dmem_resp (AW=8, LAT=2).
// Latency is counted with the accept edge as cycle 1. A vector table supplies the
// expected read data, and hand-written sequences exercise stalls and reset.
module tb_ysyx_23060111_dmem_resp;

  localparam int AW  = 8;
  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  ysyx_23060111_dmem_resp #(.AW(AW), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_mask  (req_mask),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Called #1 after a rising edge. The request is presented and accepted on the next edge.
  task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask);
    chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_mask  = mask;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Counts cycles from the accept edge (1) until rsp_valid is seen. The count is bounded.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", {31'd0, rsp_valid}, 32'd0);
    chk("rsp_rdata_after_hs", rsp_rdata, 32'd0);
    chk("rsp_err_after_hs", {31'd0, rsp_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    // addr, data, mask, expected
    tbl[0]  = '{1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b0, 32'h010, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h040, 32'h11223344, 4'hF, 32'h00000000, 1'b0};
    tbl[3]  = '{1'b1, 32'h040, 32'hAABBCCDD, 4'h2, 32'h00000000, 1'b0};
    tbl[4]  = '{1'b0, 32'h040, 32'h0,        4'h6, 32'h0022CC00, 1'b0};
    tbl[5]  = '{1'b0, 32'h040, 32'h0,        4'hF, 32'h1122CC44, 1'b0};
    tbl[6]  = '{1'b1, 32'h000, 32'h00000055, 4'hF, 32'h00000000, 1'b0};
    tbl[7]  = '{1'b0, 32'h400, 32'h0,        4'hF, 32'h00000055, 1'b0};
    tbl[8]  = '{1'b1, 32'h044, 32'hCAFEF00D, 4'hF, 32'h00000000, 1'b0};
    tbl[9]  = '{1'b1, 32'h044, 32'hFFFFFFFF, 4'h0, 32'h00000000, 1'b0};
    tbl[10] = '{1'b0, 32'h044, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
    tbl[11] = '{1'b0, 32'h010, 32'h0,        4'h9, 32'hDE0000EF, 1'b0};
    tbl[12] = '{1'b1, 32'h020, 32'hA5A5A5A5, 4'hF, 32'h00000000, 1'b0};
`ifdef YSYX_23060111_DMEM_MISALIGN_ERR_EN
    tbl[13] = '{1'b0, 32'h022, 32'h0,        4'hF, 32'h00000000, 1'b1};
`else
    tbl[13] = '{1'b0, 32'h022, 32'h0,        4'hF, 32'hA5A5A5A5, 1'b0};
`endif
    tbl[14] = '{1'b1, 32'h7FC, 32'h13579BDF, 4'hF, 32'h00000000, 1'b0};
    tbl[15] = '{1'b0, 32'h3FC, 32'h0,        4'hF, 32'h13579BDF, 1'b0};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_mask  = 4'd0;
    rsp_ready = 1'b0;

    #1;
    chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err",   {31'd0, rsp_err},   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Table-driven transactions
    for (int i = 0; i < NV; i++) begin
      issue(tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].mask);
      wait_rsp(lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(LAT));
      chk($sformatf("v%0d_rdata", i), rsp_rdata, tbl[i].exp_rdata);
      chk($sformatf("v%0d_err", i), {31'd0, rsp_err}, {31'd0, tbl[i].exp_err});
      chk($sformatf("v%0d_req_ready_in_resp", i), {31'd0, req_ready}, 32'd0);
      finish_rsp();
    end

    // Stall: response held for 5 cycles, and a competing write is ignored
    issue(1'b0, 32'h010, 32'h0, 4'hF);
    wait_rsp(lat);
    chk("stall_latency", 32'(lat), 32'(LAT));
    req_wen   = 1'b1;
    req_addr  = 32'h010;
    req_wdata = 32'h00000000;
    req_mask  = 4'hF;
    req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d_rsp_valid", c), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("stall%0d_rsp_rdata", c), rsp_rdata, 32'hDEADBEEF);
      chk($sformatf("stall%0d_req_ready", c), {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    finish_rsp();
    issue(1'b0, 32'h010, 32'h0, 4'hF);
    wait_rsp(lat);
    chk("after_stall_rdata", rsp_rdata, 32'hDEADBEEF);
    finish_rsp();

    // Reset during WAIT abandons the pending write
    issue(1'b1, 32'h020, 32'h12345678, 4'hF);
    rst = 1'b1;
    #1;
    chk("rst_wait_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_wait_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_wait_rsp_err",   {31'd0, rsp_err},   32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_hold_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue(1'b0, 32'h020, 32'h0, 4'hF);
    wait_rsp(lat);
    chk("post_rst_latency", 32'(lat), 32'(LAT));
    chk("post_rst_rdata", rsp_rdata, 32'hA5A5A5A5);
    finish_rsp();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
